// File: rtl/libstf_pkg.sv
// -----------------------------------------------------------------------------
// libstf -- shared definitions for the stream reader slice.
//
// Contents:
//   BEAT_BYTES / BEAT_SHIFT : bytes carried by one 512-bit data beat
//   REQ_LEN_W               : width of the read-request length field
//   state_e                 : reader FSM states
//   cfg_len_ok()            : a job length is usable when nonzero and
//                             a whole number of beats
// -----------------------------------------------------------------------------
package libstf;

    localparam int BEAT_BYTES = 64;
    localparam int BEAT_SHIFT = 6;
    localparam int REQ_LEN_W  = 28;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ISSUE  = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_NOTIFY = 2'd3
    } state_e;

    function automatic logic cfg_len_ok(input logic [31:0] len);
        return (len != 32'd0) && (len[BEAT_SHIFT-1:0] == '0);
    endfunction

endpackage

// File: rtl/read_request_splitter.sv
// -----------------------------------------------------------------------------
// read_request_splitter -- cuts one job into read requests of at most
// TRANSFER_LENGTH_BYTES and presents them on the sq_rd channel.
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   load            accept a new job (load_vaddr / load_len)
//   issue_en        FSM is in the issuing phase
//   credit_ok       fewer than the allowed number of requests in flight
//   sq_rd_*         registered request channel (valid/ready handshake)
// -----------------------------------------------------------------------------
module read_request_splitter
    import libstf::*;
#(
    parameter int TRANSFER_LENGTH_BYTES = 4096
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load,
    input  logic [47:0]          load_vaddr,
    input  logic [31:0]          load_len,
    input  logic                 issue_en,
    input  logic                 credit_ok,
    input  logic                 sq_rd_ready,
    output logic                 sq_rd_valid,
    output logic [47:0]          sq_rd_vaddr,
    output logic [REQ_LEN_W-1:0] sq_rd_len,
    output logic                 sq_rd_last
);

    localparam logic [31:0] XFER = 32'(TRANSFER_LENGTH_BYTES);

    logic [47:0] addr_q;
    logic [31:0] remaining_q;
    logic        fire;

    assign fire = sq_rd_valid && sq_rd_ready;

    // Address and remaining count advance on the handshake, so the next
    // request is built one cycle later from the already-updated values.
    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge value of every other flop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q      <= '0;
            remaining_q <= '0;
        end else if (load) begin
            addr_q      <= load_vaddr;
            remaining_q <= load_len;
        end else if (fire) begin
            addr_q      <= addr_q + 48'(sq_rd_len);
            remaining_q <= remaining_q - 32'(sq_rd_len);
        end
    end

    // Request fields are captured once and held until accepted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sq_rd_valid <= 1'b0;
            sq_rd_vaddr <= '0;
            sq_rd_len   <= '0;
            sq_rd_last  <= 1'b0;
        end else if (fire) begin
            sq_rd_valid <= 1'b0;
        end else if (!sq_rd_valid && issue_en && credit_ok && remaining_q != 32'd0) begin
            sq_rd_valid <= 1'b1;
            sq_rd_vaddr <= addr_q;
            if (remaining_q <= XFER) begin
                sq_rd_len  <= REQ_LEN_W'(remaining_q);
                sq_rd_last <= 1'b1;
            end else begin
                sq_rd_len  <= REQ_LEN_W'(XFER);
                sq_rd_last <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/stream_input_reader.sv
// -----------------------------------------------------------------------------
// stream_input_reader -- accepts a host-read job, issues the read requests,
// passes the returned data beats through to the user stream and raises a
// completion notification once all data and completions are in.
//
// Ports:
//   clk, rst                          clock, asynchronous active-high reset
//   cfg_*                             job descriptor (vaddr, len)
//   sq_rd_*                           read requests to the host
//   cq_rd_valid                       one read completion per pulse
//   in_t*                             host data stream (in_tlast unused)
//   out_t*                            user data stream, zero-latency
//   notify_*                          job-done notification (len)
//   err                               sticky protocol-error flag
// -----------------------------------------------------------------------------
module stream_input_reader
    import libstf::*;
#(
    parameter int AXI_STRM_ID           = 0,
    parameter int TRANSFER_LENGTH_BYTES = 4096,
    parameter int MAX_OUTSTANDING       = 8
) (
    input  logic                 clk,
    input  logic                 rst,

    input  logic                 cfg_valid,
    output logic                 cfg_ready,
    input  logic [47:0]          cfg_vaddr,
    input  logic [31:0]          cfg_len,

    output logic                 sq_rd_valid,
    input  logic                 sq_rd_ready,
    output logic [47:0]          sq_rd_vaddr,
    output logic [REQ_LEN_W-1:0] sq_rd_len,
    output logic [1:0]           sq_rd_strm,
    output logic                 sq_rd_last,

    input  logic                 cq_rd_valid,

    input  logic [511:0]         in_tdata,
    input  logic [63:0]          in_tkeep,
    input  logic                 in_tlast,
    input  logic                 in_tvalid,
    output logic                 in_tready,

    output logic [511:0]         out_tdata,
    output logic [63:0]          out_tkeep,
    output logic                 out_tlast,
    output logic                 out_tvalid,
    input  logic                 out_tready,

    output logic                 notify_valid,
    input  logic                 notify_ready,
    output logic [31:0]          notify_len,

    output logic                 err
);

    localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);

    state_e                  state;
    logic [31:0]             len_q;
    logic [31-BEAT_SHIFT:0]  beats_left;
    logic [OUT_W-1:0]        outstanding;

    logic cfg_hs, cfg_good, sq_fire, beat_fire, gate, cq_spurious;

    // Host tlast is redundant: the beat count comes from the job length.
    logic unused_in_tlast;
    assign unused_in_tlast = in_tlast;

    assign cfg_ready   = (state == ST_IDLE);
    assign cfg_hs      = cfg_valid && cfg_ready;
    assign cfg_good    = cfg_len_ok(cfg_len);
    assign sq_fire     = sq_rd_valid && sq_rd_ready;
    assign cq_spurious = cq_rd_valid && (outstanding == '0) && !sq_fire;

    // Data path: pure combinational pass-through, opened only while a job
    // still expects beats.
    assign gate       = ((state == ST_ISSUE) || (state == ST_DRAIN)) && (beats_left != '0);
    assign out_tvalid = in_tvalid && gate;
    assign in_tready  = out_tready && gate;
    assign out_tdata  = in_tdata;
    assign out_tkeep  = in_tkeep;
    assign out_tlast  = gate && (beats_left == 1);
    assign beat_fire  = out_tvalid && out_tready;

    assign notify_valid = (state == ST_NOTIFY);
    assign notify_len   = len_q;
    assign sq_rd_strm   = 2'(AXI_STRM_ID);

    read_request_splitter #(
        .TRANSFER_LENGTH_BYTES(TRANSFER_LENGTH_BYTES)
    ) u_splitter (
        .clk        (clk),
        .rst        (rst),
        .load       (cfg_hs && cfg_good),
        .load_vaddr (cfg_vaddr),
        .load_len   (cfg_len),
        .issue_en   (state == ST_ISSUE),
        .credit_ok  (outstanding < OUT_W'(MAX_OUTSTANDING)),
        .sq_rd_ready(sq_rd_ready),
        .sq_rd_valid(sq_rd_valid),
        .sq_rd_vaddr(sq_rd_vaddr),
        .sq_rd_len  (sq_rd_len),
        .sq_rd_last (sq_rd_last)
    );

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge value of every other flop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            len_q <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (cfg_hs) begin
                        len_q <= cfg_len;
                        // A bad length is consumed and flagged; no job starts.
                        if (cfg_good) state <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (sq_fire && sq_rd_last) state <= ST_DRAIN;
                end
                ST_DRAIN: begin
                    if (outstanding == '0 && beats_left == '0) state <= ST_NOTIFY;
                end
                ST_NOTIFY: begin
                    if (notify_ready) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            beats_left <= '0;
        end else if (cfg_hs && cfg_good) begin
            beats_left <= cfg_len[31:BEAT_SHIFT];
        end else if (beat_fire) begin
            beats_left <= beats_left - 1'b1;
        end
    end

    // A request and a completion in the same cycle cancel out.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            outstanding <= '0;
        end else if (sq_fire && !cq_rd_valid) begin
            outstanding <= outstanding + 1'b1;
        end else if (!sq_fire && cq_rd_valid && outstanding != '0) begin
            outstanding <= outstanding - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err <= 1'b0;
        end else if ((cfg_hs && !cfg_good) || cq_spurious) begin
            err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_stream_input_reader.sv
module tb_stream_input_reader;

    logic         clk = 1'b0;
    logic         rst;
    logic         cfg_valid, cfg_ready;
    logic [47:0]  cfg_vaddr;
    logic [31:0]  cfg_len;
    logic         sq_rd_valid, sq_rd_ready;
    logic [47:0]  sq_rd_vaddr;
    logic [27:0]  sq_rd_len;
    logic [1:0]   sq_rd_strm;
    logic         sq_rd_last;
    logic         cq_rd_valid;
    logic [511:0] in_tdata, out_tdata;
    logic [63:0]  in_tkeep, out_tkeep;
    logic         in_tlast, in_tvalid, in_tready;
    logic         out_tlast, out_tvalid, out_tready;
    logic         notify_valid, notify_ready;
    logic [31:0]  notify_len;
    logic         err;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [47:0] vaddr;
        logic [27:0] len;
        logic        last;
    } req_t;

    req_t exp_req[$];
    int   exp_beat[$];
    int   cq_due[$];

    stream_input_reader #(
        .AXI_STRM_ID(1),
        .TRANSFER_LENGTH_BYTES(4096),
        .MAX_OUTSTANDING(2)
    ) dut (
        .clk(clk), .rst(rst),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_vaddr(cfg_vaddr), .cfg_len(cfg_len),
        .sq_rd_valid(sq_rd_valid), .sq_rd_ready(sq_rd_ready),
        .sq_rd_vaddr(sq_rd_vaddr), .sq_rd_len(sq_rd_len),
        .sq_rd_strm(sq_rd_strm), .sq_rd_last(sq_rd_last),
        .cq_rd_valid(cq_rd_valid),
        .in_tdata(in_tdata), .in_tkeep(in_tkeep), .in_tlast(in_tlast),
        .in_tvalid(in_tvalid), .in_tready(in_tready),
        .out_tdata(out_tdata), .out_tkeep(out_tkeep), .out_tlast(out_tlast),
        .out_tvalid(out_tvalid), .out_tready(out_tready),
        .notify_valid(notify_valid), .notify_ready(notify_ready),
        .notify_len(notify_len),
        .err(err)
    );

    always #5 clk = ~clk;

    function automatic logic [511:0] pat(input int idx);
        logic [31:0] w;
        w = 32'(idx) ^ 32'hC0DE_0000;
        return {16{w}};
    endfunction

    function automatic logic [63:0] keep_pat(input int idx);
        logic [31:0] w;
        w = 32'(idx) ^ 32'h5A5A_5A5A;
        return {w, ~w};
    endfunction

    task automatic idle_inputs();
        cfg_valid = 0; cfg_vaddr = '0; cfg_len = '0;
        sq_rd_ready = 0; cq_rd_valid = 0;
        in_tdata = '0; in_tkeep = '0; in_tlast = 0; in_tvalid = 0;
        out_tready = 0; notify_ready = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        idle_inputs();
        rst = 1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 0;
    endtask

    task automatic send_cfg(input logic [47:0] vaddr, input logic [31:0] len);
        @(negedge clk);
        cfg_valid = 1; cfg_vaddr = vaddr; cfg_len = len;
        #1;
        checks++;
        if (cfg_ready !== 1'b1) begin
            errors++;
            $display("FAIL cfg_ready: got %b want 1", cfg_ready);
        end
        @(posedge clk);
        #1 cfg_valid = 0;
    endtask

    // Full job with a host model: data for a request becomes available once
    // the request is accepted, and its completion arrives after that data
    // has left on the user stream.
    task automatic run_job(input logic [47:0] vaddr, input int len,
                           input bit throttle, input int abort_at);
        logic [47:0] a;
        int   rem, l, total, in_idx, out_idx, avail, cyc, e;
        bit   done;
        req_t r, q;
        exp_req.delete(); exp_beat.delete(); cq_due.delete();
        a = vaddr; rem = len;
        while (rem > 0) begin
            l = (rem > 4096) ? 4096 : rem;
            r.vaddr = a; r.len = 28'(l); r.last = (l == rem);
            exp_req.push_back(r);
            a = a + 48'(l); rem = rem - l;
        end
        total = len / 64; in_idx = 0; out_idx = 0; avail = 0; cyc = 0; done = 0;
        send_cfg(vaddr, 32'(len));
        while (!done && cyc < 5000 && !(abort_at > 0 && cyc >= abort_at)) begin
            @(negedge clk);
            sq_rd_ready  = throttle ? 1'($urandom_range(0, 1)) : 1'b1;
            out_tready   = throttle ? 1'($urandom_range(0, 1)) : 1'b1;
            notify_ready = throttle ? 1'($urandom_range(0, 1)) : 1'b1;
            in_tvalid    = (in_idx < avail);
            in_tdata     = pat(in_idx);
            in_tkeep     = keep_pat(in_idx);
            cq_rd_valid  = (cq_due.size() != 0) && (out_idx >= cq_due[0]);
            #1;
            if (sq_rd_valid && sq_rd_ready) begin
                checks++;
                if (exp_req.size() == 0) begin
                    errors++;
                    $display("FAIL extra_request: got vaddr=%h want none", sq_rd_vaddr);
                end else begin
                    q = exp_req.pop_front();
                    if (sq_rd_vaddr !== q.vaddr || sq_rd_len !== q.len ||
                        sq_rd_last !== q.last || sq_rd_strm !== 2'd1) begin
                        errors++;
                        $display("FAIL request: got vaddr=%h len=%0d last=%b strm=%0d want vaddr=%h len=%0d last=%b strm=1",
                                 sq_rd_vaddr, sq_rd_len, sq_rd_last, sq_rd_strm, q.vaddr, q.len, q.last);
                    end
                    for (int i = 0; i < int'(q.len) / 64; i++) exp_beat.push_back(avail + i);
                    avail = avail + int'(q.len) / 64;
                    cq_due.push_back(avail);
                end
            end
            if (out_tvalid && out_tready) begin
                checks++;
                if (exp_beat.size() == 0) begin
                    errors++;
                    $display("FAIL extra_beat: got beat with no request outstanding");
                end else begin
                    e = exp_beat.pop_front();
                    if (out_tdata !== pat(e) || out_tkeep !== keep_pat(e) ||
                        out_tlast !== (e == total - 1) || in_tready !== 1'b1) begin
                        errors++;
                        $display("FAIL beat %0d: got data=%h keep=%h last=%b in_tready=%b want data=%h keep=%h last=%b",
                                 e, out_tdata[31:0], out_tkeep, out_tlast, in_tready,
                                 pat(e) & 512'hFFFF_FFFF, keep_pat(e), (e == total - 1));
                    end
                end
                out_idx++;
            end
            if (in_tvalid && in_tready) in_idx++;
            if (cq_rd_valid) void'(cq_due.pop_front());
            if (notify_valid && notify_ready) begin
                checks++;
                if (notify_len !== 32'(len) || exp_req.size() != 0 || out_idx != total) begin
                    errors++;
                    $display("FAIL notify: got len=%0d beats=%0d reqs_left=%0d want len=%0d beats=%0d reqs_left=0",
                             notify_len, out_idx, exp_req.size(), len, total);
                end
                done = 1;
            end
            cyc++;
        end
        if (abort_at == 0) begin
            checks++;
            if (!done) begin
                errors++;
                $display("FAIL job_timeout: got no notify after %0d cycles want notify", cyc);
            end else begin
                @(negedge clk);
                #1;
                checks++;
                if (cfg_ready !== 1'b1) begin
                    errors++;
                    $display("FAIL idle_after_notify: got cfg_ready=%b want 1", cfg_ready);
                end
            end
        end
        cq_rd_valid = 0; in_tvalid = 0;
    endtask

    task automatic test_reset();
        do_reset();
        in_tvalid = 1; out_tready = 1;
        #1;
        checks++;
        if (cfg_ready !== 1 || sq_rd_valid !== 0 || out_tvalid !== 0 || in_tready !== 0 ||
            out_tlast !== 0 || notify_valid !== 0 || err !== 0) begin
            errors++;
            $display("FAIL reset_state: got cfg_ready=%b sq=%b out_v=%b in_r=%b last=%b notify=%b err=%b want 1 0 0 0 0 0 0",
                     cfg_ready, sq_rd_valid, out_tvalid, in_tready, out_tlast, notify_valid, err);
        end
        in_tvalid = 0; out_tready = 0;
    endtask

    task automatic test_two_requests();
        do_reset();
        run_job(48'h1000, 8192, 0, 0);
    endtask

    task automatic test_short_tail();
        do_reset();
        run_job(48'h4_0000, 4160, 0, 0);
    endtask

    task automatic test_bad_len();
        logic [31:0] lens [2];
        bit seen;
        lens[0] = 32'd100; lens[1] = 32'd0;
        for (int k = 0; k < 2; k++) begin
            do_reset();
            sq_rd_ready = 1;
            send_cfg(48'h9000, lens[k]);
            seen = 0;
            for (int c = 0; c < 10; c++) begin
                @(negedge clk);
                #1;
                if (sq_rd_valid) seen = 1;
            end
            checks++;
            if (err !== 1 || cfg_ready !== 1 || seen) begin
                errors++;
                $display("FAIL bad_len %0d: got err=%b cfg_ready=%b req_seen=%b want 1 1 0",
                         lens[k], err, cfg_ready, seen);
            end
        end
        do_reset();
    endtask

    task automatic test_outstanding_limit();
        logic [47:0] base;
        int   hs;
        bit   found;
        base = 48'h10_0000;
        do_reset();
        sq_rd_ready = 1;
        send_cfg(base, 32'd16384);
        hs = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            #1;
            if (sq_rd_valid && sq_rd_ready) hs++;
        end
        checks++;
        if (hs != 2) begin
            errors++;
            $display("FAIL credit_limit: got %0d requests want 2", hs);
        end
        // One completion frees a credit; hold the third request unaccepted.
        @(negedge clk);
        sq_rd_ready = 0; cq_rd_valid = 1;
        @(negedge clk);
        cq_rd_valid = 0;
        found = 0;
        for (int c = 0; c < 10 && !found; c++) begin
            @(negedge clk);
            #1;
            if (sq_rd_valid) found = 1;
        end
        checks++;
        if (!found || sq_rd_vaddr !== base + 48'd8192) begin
            errors++;
            $display("FAIL third_request: got valid=%b vaddr=%h want 1 %h", found, sq_rd_vaddr, base + 48'd8192);
        end
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (sq_rd_valid !== 1 || sq_rd_vaddr !== base + 48'd8192 || sq_rd_len !== 28'd4096) begin
            errors++;
            $display("FAIL request_hold: got valid=%b vaddr=%h len=%0d want 1 %h 4096",
                     sq_rd_valid, sq_rd_vaddr, sq_rd_len, base + 48'd8192);
        end
        // Accept it in the same cycle as a completion: count stays at 1.
        @(negedge clk);
        sq_rd_ready = 1; cq_rd_valid = 1;
        @(negedge clk);
        cq_rd_valid = 0;
        found = 0;
        for (int c = 0; c < 10 && !found; c++) begin
            #1;
            if (sq_rd_valid && sq_rd_ready) found = 1;
            else @(negedge clk);
        end
        checks++;
        if (!found || sq_rd_vaddr !== base + 48'd12288 || sq_rd_last !== 1) begin
            errors++;
            $display("FAIL simultaneous_hs_cq: got fourth=%b vaddr=%h last=%b want 1 %h 1",
                     found, sq_rd_vaddr, sq_rd_last, base + 48'd12288);
        end
        do_reset();
    endtask

    task automatic test_spurious_cq();
        do_reset();
        #1;
        checks++;
        if (err !== 0) begin
            errors++;
            $display("FAIL err_clear: got %b want 0", err);
        end
        @(negedge clk);
        cq_rd_valid = 1;
        @(negedge clk);
        cq_rd_valid = 0;
        #1;
        checks++;
        if (err !== 1 || cfg_ready !== 1) begin
            errors++;
            $display("FAIL spurious_cq: got err=%b cfg_ready=%b want 1 1", err, cfg_ready);
        end
        do_reset();
    endtask

    task automatic test_throttle_reset();
        do_reset();
        run_job(48'h8000, 16384, 1, 0);
        do_reset();
        run_job(48'h2_0000, 16384, 1, 150);
        @(negedge clk);
        cfg_valid = 0; cq_rd_valid = 0; in_tvalid = 1; out_tready = 1;
        sq_rd_ready = 1; notify_ready = 1;
        #2 rst = 1;
        #1;
        checks++;
        if (cfg_ready !== 1 || sq_rd_valid !== 0 || out_tvalid !== 0 || in_tready !== 0 ||
            out_tlast !== 0 || notify_valid !== 0 || err !== 0) begin
            errors++;
            $display("FAIL mid_job_reset: got cfg_ready=%b sq=%b out_v=%b in_r=%b last=%b notify=%b err=%b want 1 0 0 0 0 0 0",
                     cfg_ready, sq_rd_valid, out_tvalid, in_tready, out_tlast, notify_valid, err);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        idle_inputs();
        rst = 0;
        run_job(48'h3000, 128, 0, 0);
    endtask

    initial begin
        rst = 1;
        idle_inputs();
        test_reset();
        test_two_requests();
        test_short_tail();
        test_bad_len();
        test_outstanding_limit();
        test_spurious_cq();
        test_throttle_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
